// File: rtl/sr_cmd_debounce.sv
// Set/reset command front end: 2-flop synchronizer and debounce FSM per channel,
// then registered one-cycle s/r pulses arbitrated so s and r are never high together.
module sr_cmd_debounce #(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 3,
  parameter int PRIO       = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic s_raw,
  input  logic r_raw,
  input  logic conflict_clr,
  output logic s,
  output logic r,
  output logic s_lvl,
  output logic r_lvl,
  output logic conflict
);

  typedef enum logic [1:0] {
    STABLE_LO,
    WAIT_HI,
    STABLE_HI,
    WAIT_LO
  } deb_state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Channel 0 is set, channel 1 is reset.
  logic [1:0] w_raw;
  logic [1:0] w_lvl;
  logic [1:0] w_p;

  assign w_raw = {r_raw, s_raw};

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic             r_s1;
    logic             r_s2;
    deb_state_t       r_state;
    deb_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_level;
    logic             w_level_nxt;
    logic             w_edge;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_s1 <= 1'b0;
        r_s2 <= 1'b0;
      end else begin
        r_s1 <= w_raw[ch];
        r_s2 <= r_s1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state <= STABLE_LO;
        r_cnt   <= '0;
        r_level <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_level <= w_level_nxt;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_level_nxt = r_level;
      case (r_state)
        STABLE_LO: begin
          if (r_s2) begin
            w_state_nxt = WAIT_HI;
            w_cnt_nxt   = CNT_ONE;
          end
        end
        WAIT_HI: begin
          if (!r_s2) begin
            w_state_nxt = STABLE_LO;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt = STABLE_HI;
            w_cnt_nxt   = '0;
            w_level_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        STABLE_HI: begin
          if (!r_s2) begin
            w_state_nxt = WAIT_LO;
            w_cnt_nxt   = CNT_ONE;
          end
        end
        WAIT_LO: begin
          if (r_s2) begin
            w_state_nxt = STABLE_HI;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt = STABLE_LO;
            w_cnt_nxt   = '0;
            w_level_nxt = 1'b0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        default: begin
          w_state_nxt = STABLE_LO;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b0;
        end
      endcase
    end

    // Edge candidate only on the accepting WAIT_HI -> STABLE_HI step.
    always_comb begin
      w_edge = 1'b0;
      if ((r_state == WAIT_HI) && r_s2 && (r_cnt == CNT_LAST)) begin
        w_edge = 1'b1;
      end
    end

    assign w_p[ch]   = w_edge;
    assign w_lvl[ch] = r_level;
  end

  logic r_s_pulse;
  logic r_r_pulse;
  logic r_conflict;
  logic w_both;

  assign w_both = w_p[0] & w_p[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_pulse  <= 1'b0;
      r_r_pulse  <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_s_pulse <= w_p[0] & ~w_p[1];
      r_r_pulse <= w_both ? (PRIO == 1) : w_p[1];
      // A new conflict outranks a clear in the same cycle.
      if (w_both) begin
        r_conflict <= 1'b1;
      end else if (conflict_clr) begin
        r_conflict <= 1'b0;
      end
    end
  end

  assign s        = r_s_pulse;
  assign r        = r_r_pulse;
  assign s_lvl    = w_lvl[0];
  assign r_lvl    = w_lvl[1];
  assign conflict = r_conflict;

endmodule

// File: tb/tb_sr_cmd_debounce.sv
// Scoreboard bench: directed scenarios then random bouncing inputs, checked against a
// run-length reference model for both conflict policies.
module tb_sr_cmd_debounce;

  localparam int DEB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic s_raw = 1'b0;
  logic r_raw = 1'b0;
  logic clr = 1'b0;

  logic s0, r0, sl0, rl0, c0;
  logic s1, r1, sl1, rl1, c1;

  sr_cmd_debounce #(.DEB_CYCLES(DEB), .CNT_W(3), .PRIO(0)) u_dut0 (
    .clk(clk), .rst(rst), .s_raw(s_raw), .r_raw(r_raw), .conflict_clr(clr),
    .s(s0), .r(r0), .s_lvl(sl0), .r_lvl(rl0), .conflict(c0)
  );

  sr_cmd_debounce #(.DEB_CYCLES(DEB), .CNT_W(3), .PRIO(1)) u_dut1 (
    .clk(clk), .rst(rst), .s_raw(s_raw), .r_raw(r_raw), .conflict_clr(clr),
    .s(s1), .r(r1), .s_lvl(sl1), .r_lvl(rl1), .conflict(c1)
  );

  int errors = 0;
  int checks = 0;

  // Expected {s,r,s_lvl,r_lvl,conflict} for PRIO=0 (high half) and PRIO=1 (low half).
  logic [9:0] exp_q[$];

  // Reference model: synchronized sample stream and trailing run length per channel.
  bit m1[2];
  bit m2[2];
  bit run_v[2];
  int run_n[2];
  bit lvl[2];
  bit conf;

  task automatic model_edge(input bit i_rst, input bit i_s, input bit i_r, input bit i_clr,
                            output logic [4:0] e0, output logic [4:0] e1);
    bit raw[2];
    bit rise[2];
    bit y;
    bit both;
    raw[0] = i_s;
    raw[1] = i_r;
    rise[0] = 1'b0;
    rise[1] = 1'b0;
    if (i_rst) begin
      for (int c = 0; c < 2; c++) begin
        m1[c] = 1'b0; m2[c] = 1'b0; run_v[c] = 1'b0; run_n[c] = 0; lvl[c] = 1'b0;
      end
      conf = 1'b0;
      e0 = '0;
      e1 = '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        y = m2[c];
        m2[c] = m1[c];
        m1[c] = raw[c];
        if (y == run_v[c]) run_n[c]++;
        else begin
          run_v[c] = y;
          run_n[c] = 1;
        end
        if (run_v[c] != lvl[c] && run_n[c] >= DEB) begin
          lvl[c] = run_v[c];
          rise[c] = run_v[c];
        end
      end
      both = rise[0] & rise[1];
      if (both) conf = 1'b1;
      else if (i_clr) conf = 1'b0;
      e0 = {rise[0] & ~rise[1], rise[1] & ~rise[0], lvl[0], lvl[1], conf};
      e1 = {rise[0] & ~rise[1], rise[1], lvl[0], lvl[1], conf};
    end
  endtask

  task automatic step(input bit i_rst, input bit i_s, input bit i_r, input bit i_clr);
    logic [4:0] e0;
    logic [4:0] e1;
    @(negedge clk);
    rst = i_rst;
    s_raw = i_s;
    r_raw = i_r;
    clr = i_clr;
    model_edge(i_rst, i_s, i_r, i_clr, e0, e1);
    exp_q.push_back({e0, e1});
  endtask

  task automatic hold_n(input int n, input bit i_rst, input bit i_s, input bit i_r, input bit i_clr);
    for (int i = 0; i < n; i++) step(i_rst, i_s, i_r, i_clr);
  endtask

  // Monitor: outputs are presented every cycle; compare just after each active edge.
  initial begin
    logic [9:0] exp;
    logic [4:0] got0;
    logic [4:0] got1;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        got0 = {s0, r0, sl0, rl0, c0};
        got1 = {s1, r1, sl1, rl1, c1};
        checks++;
        if (got0 !== exp[9:5]) begin
          errors++;
          $display("FAIL prio0_outputs t=%0t got {s,r,s_lvl,r_lvl,conflict}=%b expected %b",
                   $time, got0, exp[9:5]);
        end
        checks++;
        if (got1 !== exp[4:0]) begin
          errors++;
          $display("FAIL prio1_outputs t=%0t got {s,r,s_lvl,r_lvl,conflict}=%b expected %b",
                   $time, got1, exp[4:0]);
        end
        checks++;
        if (((s0 & r0) | (s1 & r1)) !== 1'b0) begin
          errors++;
          $display("FAIL s_and_r_exclusive t=%0t got s0&r0=%b s1&r1=%b expected 0",
                   $time, s0 & r0, s1 & r1);
        end
      end
    end
  end

  initial begin
    int hold[2];
    bit cur[2];
    bit rnd_rst;
    bit rnd_clr;
    hold[0] = 0;
    hold[1] = 0;
    cur[0] = 1'b0;
    cur[1] = 1'b0;

    hold_n(3, 1, 0, 0, 0);
    hold_n(12, 0, 0, 0, 0);
    // Clean set, then release.
    hold_n(14, 0, 1, 0, 0);
    hold_n(14, 0, 0, 0, 0);
    // Bounce: 3 high, 1 low, then steady high.
    hold_n(3, 0, 1, 0, 0);
    hold_n(1, 0, 0, 0, 0);
    hold_n(12, 0, 1, 0, 0);
    hold_n(14, 0, 0, 0, 0);
    // Clean reset channel.
    hold_n(12, 0, 0, 1, 0);
    hold_n(12, 0, 0, 0, 0);
    // Simultaneous rise, then clear.
    hold_n(12, 0, 1, 1, 0);
    hold_n(12, 0, 0, 0, 0);
    hold_n(1, 0, 0, 0, 1);
    hold_n(2, 0, 0, 0, 0);
    // Reset while set channel is mid-count, raw held high through it.
    hold_n(4, 0, 1, 0, 0);
    hold_n(1, 1, 1, 0, 0);
    hold_n(12, 0, 1, 0, 0);
    hold_n(14, 0, 0, 0, 0);
    // Clear coincident with a new conflict, then clear alone.
    hold_n(5, 0, 1, 1, 0);
    hold_n(2, 0, 1, 1, 1);
    hold_n(6, 0, 1, 1, 0);
    hold_n(14, 0, 0, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < 2; c++) begin
        if (hold[c] == 0) begin
          cur[c] = 1'($urandom_range(0, 1));
          hold[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                : int'($urandom_range(2, 9));
        end
        hold[c]--;
      end
      if ($urandom_range(0, 80) == 0) begin
        cur[0] = 1'b1; cur[1] = 1'b1; hold[0] = 8; hold[1] = 8;
      end
      rnd_rst = ($urandom_range(0, 299) == 0);
      rnd_clr = ($urandom_range(0, 15) == 0);
      step(rnd_rst, cur[0], cur[1], rnd_clr);
    end

    for (int i = 0; i < 5; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #2;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
